eth_hdr_framer: RTL and testbench
=================================

Name: eth_hdr_framer

Overview:
- Parametrised successor of the Ethernet pixel-stream controller.
- Once per packet it snapshots a configurable-width parameter vector plus an optional 16-bit frame sequence number, and serialises them MSB-first as a header.
- It then passes the pixel byte stream through to the UDP/Ethernet packetiser.
- Adds a ready/valid output handshake with backpressure, a variable header length, and sequence numbering.

Parameters:
- HDR_BYTES, 12, number of parameter bytes in i_param (1..32).
- SEQ_EN, 1, when 1 a 16-bit sequence number precedes the parameter bytes.
- LEN_W, 15, width of the byte-count field.
- ROW_W, 8, width of the row-number field.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_param  in  HDR_BYTES*8  parameter vector; byte [HDR_BYTES*8-1 -: 8] is sent first.
- i_full  in  1  upstream line buffer holds a full packet.
- i_packet_last  in  1  packetiser signals end of packet.
- i_eth_busy  in  1  MAC/packetiser busy.
- i_pix_data  in  8  pixel byte.
- i_pix_valid  in  1  pixel byte valid.
- o_pix_ready  out  1  framer accepts a pixel byte this cycle.
- i_data_byte  in  LEN_W  payload length for the current packet.
- i_row_number  in  ROW_W  row index.
- i_sof  in  1  start of frame.
- i_out_ready  in  1  downstream accepts o_data.
- o_data  out  8  output byte.
- o_valid  out  1  o_data valid.
- o_data_byte  out  LEN_W  length of the current segment.
- o_row_number  out  ROW_W  row index.
- o_sof  out  1  start of frame.
- o_hdr_flag  out  1  current output belongs to the header.
- o_busy  out  1  busy indication to upstream.
- o_seq  out  16  sequence number of the packet in flight.

Behaviour:
- Derived constant: TOT = HDR_BYTES + 2*SEQ_EN.
- Reset: state=IDLE; all outputs 0; internal sequence counter 0.
- States: IDLE, WAIT, HDR, DATA.
- IDLE -> WAIT when !i_eth_busy && !i_full.
- WAIT -> HDR when !i_eth_busy && i_full. On the transition cycle:
  - shift register <= {seq, i_param} (seq omitted if SEQ_EN=0);
  - byte counter <= 0;
  - o_seq <= seq.
- HDR:
  - o_valid=1, o_hdr_flag=1, o_data=MS byte of the shift register, o_data_byte=TOT, o_row_number=0, o_sof=0.
  - On (o_valid && i_out_ready): shift left 8 and increment the counter.
  - When the counter reaches TOT-1 and the byte is accepted: -> DATA; o_valid drops next cycle unless a pixel is loaded.
  - Stalled (i_out_ready=0): o_data and the counter hold.
- DATA:
  - o_pix_ready = !o_valid || i_out_ready (single output register, no skid buffer).
  - A pixel is accepted when i_pix_valid && o_pix_ready. On acceptance, register i_pix_data, i_data_byte, i_row_number and i_sof into the outputs; o_valid=1; o_hdr_flag=0.
  - If o_valid && i_out_ready with no new pixel: o_valid <= 0.
  - o_pix_ready = 0 in every state other than DATA.
- DATA -> WAIT on i_packet_last:
  - seq increments by 1, wrapping 0xFFFF -> 0x0000.
  - A pixel accepted in the same cycle is still registered and remains valid until i_out_ready; WAIT is not left while o_valid=1.
- o_busy:
  - 1 in WAIT and HDR;
  - in IDLE and DATA it is registered i_eth_busy.
- Header latency: first header byte valid 1 cycle after the WAIT->HDR transition. Minimum header duration is TOT cycles with i_out_ready held high.
- Simultaneous events:
  - i_full deasserting during HDR is ignored (the header completes).
  - i_packet_last during HDR is ignored.
- Reset mid-operation:
  - returns to IDLE next cycle; o_valid=0; a partial header is discarded;
  - the sequence counter resets to 0.
- Widths: all counters are $clog2(TOT+1) bits; no truncation of i_param.

Test Plan:
- Defaults: i_param=96'h0123_4567_89AB_CDEF_0011_2233, seq=0, i_out_ready=1 -> 14 header bytes 00,00,01,23,...,33 on consecutive cycles; o_data_byte=14; o_hdr_flag=1 throughout; then DATA.
- Backpressure: i_out_ready low for 3 cycles after the 5th header byte -> o_data holds 0x45 for 4 cycles; no byte dropped or duplicated; total still 14 bytes.
- DATA pass-through: 8 pixels 0x10..0x17, i_row_number=5, i_data_byte=8, i_out_ready toggling 1/0 -> output order 0x10..0x17; o_pix_ready=0 whenever o_valid=1 && i_out_ready=0.
- Sequence: three packets each ended by i_packet_last -> o_seq 0,1,2. With seq preset by running 65536 packets (or forcing) -> wraps 0xFFFF -> 0x0000.
- SEQ_EN=0, HDR_BYTES=4, i_param=32'hDEADBEEF -> header DE,AD,BE,EF; o_data_byte=4.
- Reset asserted on the 3rd header cycle -> next cycle: o_valid=0, state IDLE, o_seq=0. A fresh i_full then produces a complete header from byte 0.

Source files
------------

// File: rtl/eth_hdr_framer.sv
// Per-packet header framer: serialises {seq, i_param} MSB-first, then passes pixel bytes
// through a single ready/valid output register towards the UDP/Ethernet packetiser.
//
// state  | meaning
// IDLE   | after reset, waiting for MAC idle and an empty line buffer
// WAIT   | armed, waiting for a full packet in the line buffer
// HDR    | shifting header bytes out, one per accepted transfer
// DATA   | pixel pass-through until the packetiser signals end of packet
module eth_hdr_framer #(
   parameter int HDR_BYTES = 12,
   parameter int SEQ_EN    = 1,
   parameter int LEN_W     = 15,
   parameter int ROW_W     = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [HDR_BYTES*8-1:0] i_param,
   input  logic                   i_full,
   input  logic                   i_packet_last,
   input  logic                   i_eth_busy,
   input  logic [7:0]             i_pix_data,
   input  logic                   i_pix_valid,
   output logic                   o_pix_ready,
   input  logic [LEN_W-1:0]       i_data_byte,
   input  logic [ROW_W-1:0]       i_row_number,
   input  logic                   i_sof,
   input  logic                   i_out_ready,
   output logic [7:0]             o_data,
   output logic                   o_valid,
   output logic [LEN_W-1:0]       o_data_byte,
   output logic [ROW_W-1:0]       o_row_number,
   output logic                   o_sof,
   output logic                   o_hdr_flag,
   output logic                   o_busy,
   output logic [15:0]            o_seq
);

   localparam int TOT = HDR_BYTES + 2*SEQ_EN;
   localparam int SW  = TOT*8;
   localparam int CW  = $clog2(TOT+1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(TOT-1);
   localparam logic [LEN_W-1:0] HDR_LEN  = LEN_W'(TOT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HDR, S_DATA} state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     sr_q, sr_d, sr_load, sr_shift;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [15:0]       seq_q, seq_d;
   logic [15:0]       oseq_q, oseq_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              sof_q, sof_d;
   logic              hdr_q, hdr_d;
   logic              busy_q, busy_d;
   logic              pix_ready, pix_acc, hdr_acc;

   generate
      if (SEQ_EN != 0) begin : g_seq
         assign sr_load = {seq_q, i_param};
      end else begin : g_noseq
         assign sr_load = i_param;
      end
   endgenerate

   assign sr_shift  = sr_q << 8;
   // Single output register, no skid: a new pixel only when the slot is empty or draining.
   assign pix_ready = (state_q == S_DATA) && (!valid_q || i_out_ready);
   assign pix_acc   = i_pix_valid && pix_ready;
   assign hdr_acc   = (state_q == S_HDR) && valid_q && i_out_ready;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      seq_d   = seq_q;
      oseq_d  = oseq_q;
      data_d  = data_q;
      valid_d = valid_q;
      len_d   = len_q;
      row_d   = row_q;
      sof_d   = sof_q;
      hdr_d   = hdr_q;
      case (state_q)
         S_IDLE: begin
            if (!i_eth_busy && !i_full) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (valid_q && i_out_ready) valid_d = 1'b0;
            if (!i_eth_busy && i_full && !valid_q) begin
               state_d = S_HDR;
               sr_d    = sr_load;
               cnt_d   = '0;
               oseq_d  = seq_q;
               data_d  = sr_load[SW-1 -: 8];
               valid_d = 1'b1;
               hdr_d   = 1'b1;
               len_d   = HDR_LEN;
               row_d   = '0;
               sof_d   = 1'b0;
            end
         end
         S_HDR: begin
            if (hdr_acc) begin
               sr_d   = sr_shift;
               cnt_d  = cnt_q + 1'b1;
               data_d = sr_shift[SW-1 -: 8];
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DATA;
                  valid_d = 1'b0;
                  hdr_d   = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (pix_acc) begin
               data_d  = i_pix_data;
               len_d   = i_data_byte;
               row_d   = i_row_number;
               sof_d   = i_sof;
               valid_d = 1'b1;
               hdr_d   = 1'b0;
            end else if (valid_q && i_out_ready) begin
               valid_d = 1'b0;
            end
            if (i_packet_last) begin
               state_d = S_WAIT;
               seq_d   = seq_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_WAIT || state_d == S_HDR) ? 1'b1 : i_eth_busy;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         seq_q   <= '0;
         oseq_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         len_q   <= '0;
         row_q   <= '0;
         sof_q   <= 1'b0;
         hdr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         seq_q   <= seq_d;
         oseq_q  <= oseq_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         len_q   <= len_d;
         row_q   <= row_d;
         sof_q   <= sof_d;
         hdr_q   <= hdr_d;
         busy_q  <= busy_d;
      end
   end

   assign o_pix_ready  = pix_ready;
   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_data_byte  = len_q;
   assign o_row_number = row_q;
   assign o_sof        = sof_q;
   assign o_hdr_flag   = hdr_q;
   assign o_busy       = busy_q;
   assign o_seq        = oseq_q;

endmodule

// File: tb/tb_eth_hdr_framer.sv
// Scoreboard bench for eth_hdr_framer: default 12-byte+seq instance and a 4-byte no-seq instance.
module tb_eth_hdr_framer;

   localparam logic [95:0] PARAM = 96'h0123_4567_89AB_CDEF_0011_2233;

   typedef struct packed {
      logic [7:0]  d;
      logic        h;
      logic [14:0] len;
      logic [7:0]  row;
      logic        sof;
   } exp_t;

   logic        i_clk, i_rst;
   logic [95:0] i_param;
   logic        i_full, i_packet_last, i_eth_busy;
   logic [7:0]  i_pix_data;
   logic        i_pix_valid, i_sof, i_out_ready;
   logic [14:0] i_data_byte;
   logic [7:0]  i_row_number;
   logic        o_pix_ready, o_valid, o_sof, o_hdr_flag, o_busy;
   logic [7:0]  o_data, o_row_number;
   logic [14:0] o_data_byte;
   logic [15:0] o_seq;

   logic [31:0] i_param2;
   logic        i_full2, i_pix_valid2;
   logic        o_pix_ready2, o_valid2, o_sof2, o_hdr_flag2, o_busy2;
   logic [7:0]  o_data2, o_row_number2;
   logic [14:0] o_data_byte2;
   logic [15:0] o_seq2;

   int   n_chk = 0;
   int   n_pass = 0;
   int   hs_cnt = 0;
   exp_t q1[$];
   logic [7:0] q2[$];
   exp_t mon_e;
   logic [7:0] mon_b;

   eth_hdr_framer u_dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_param(i_param), .i_full(i_full),
      .i_packet_last(i_packet_last), .i_eth_busy(i_eth_busy),
      .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
      .i_data_byte(i_data_byte), .i_row_number(i_row_number), .i_sof(i_sof),
      .i_out_ready(i_out_ready), .o_data(o_data), .o_valid(o_valid),
      .o_data_byte(o_data_byte), .o_row_number(o_row_number), .o_sof(o_sof),
      .o_hdr_flag(o_hdr_flag), .o_busy(o_busy), .o_seq(o_seq)
   );

   eth_hdr_framer #(.HDR_BYTES(4), .SEQ_EN(0), .LEN_W(15), .ROW_W(8)) u_dut4 (
      .i_clk(i_clk), .i_rst(i_rst), .i_param(i_param2), .i_full(i_full2),
      .i_packet_last(i_packet_last), .i_eth_busy(i_eth_busy),
      .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid2), .o_pix_ready(o_pix_ready2),
      .i_data_byte(i_data_byte), .i_row_number(i_row_number), .i_sof(i_sof),
      .i_out_ready(i_out_ready), .o_data(o_data2), .o_valid(o_valid2),
      .o_data_byte(o_data_byte2), .o_row_number(o_row_number2), .o_sof(o_sof2),
      .o_hdr_flag(o_hdr_flag2), .o_busy(o_busy2), .o_seq(o_seq2)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Output monitors: every accepted transfer is popped from the scoreboard and compared.
   always @(negedge i_clk) begin
      if (!i_rst && o_valid && i_out_ready) begin
         hs_cnt++;
         n_chk++;
         if (q1.size() == 0) begin
            $display("FAIL out_unexpected: got data=%h hdr=%b, expected no transfer", o_data, o_hdr_flag);
         end else begin
            mon_e = q1.pop_front();
            if ({o_data, o_hdr_flag, o_data_byte, o_row_number, o_sof} !== mon_e)
               $display("FAIL out_byte: got d=%h h=%b len=%0d row=%0d sof=%b, expected d=%h h=%b len=%0d row=%0d sof=%b",
                        o_data, o_hdr_flag, o_data_byte, o_row_number, o_sof,
                        mon_e.d, mon_e.h, mon_e.len, mon_e.row, mon_e.sof);
            else n_pass++;
         end
      end
      if (!i_rst && o_valid && !i_out_ready) begin
         n_chk++;
         if (o_pix_ready !== 1'b0) $display("FAIL pix_ready_stall: got %b expected 0", o_pix_ready);
         else n_pass++;
      end
      if (!i_rst && o_valid2 && i_out_ready) begin
         n_chk++;
         if (q2.size() == 0) begin
            $display("FAIL out2_unexpected: got data=%h, expected no transfer", o_data2);
         end else begin
            mon_b = q2.pop_front();
            if (o_data2 !== mon_b || o_hdr_flag2 !== 1'b1)
               $display("FAIL out2_byte: got %h hdr=%b expected %h hdr=1", o_data2, o_hdr_flag2, mon_b);
            else n_pass++;
         end
      end
   end

   task automatic test_reset();
      i_rst = 1'b1; i_param = PARAM; i_full = 1'b0; i_packet_last = 1'b0; i_eth_busy = 1'b0;
      i_pix_data = '0; i_pix_valid = 1'b0; i_sof = 1'b0; i_out_ready = 1'b1;
      i_data_byte = '0; i_row_number = '0;
      i_param2 = 32'hDEADBEEF; i_full2 = 1'b0; i_pix_valid2 = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      n_chk++;
      if ({o_valid, o_data, o_hdr_flag, o_busy, o_seq, o_pix_ready, o_sof} !== '0)
         $display("FAIL reset_outputs: got v=%b d=%h h=%b busy=%b seq=%h pr=%b sof=%b, expected all 0",
                  o_valid, o_data, o_hdr_flag, o_busy, o_seq, o_pix_ready, o_sof);
      else n_pass++;
      @(posedge i_clk); #1;
      n_chk++;
      if (o_busy !== 1'b1 || o_valid !== 1'b0) $display("FAIL wait_busy: got busy=%b valid=%b expected 1 0", o_busy, o_valid);
      else n_pass++;
   endtask

   // Starts from WAIT; leaves the DUT in DATA with the header fully drained.
   task automatic run_header(input logic [15:0] exp_seq, input bit stall);
      logic [111:0] hv;
      exp_t e;
      int cyc, c;
      hv = {exp_seq, PARAM};
      for (int i = 0; i < 14; i++) begin
         e.d = hv[111-8*i -: 8]; e.h = 1'b1; e.len = 15'd14; e.row = 8'd0; e.sof = 1'b0;
         q1.push_back(e);
      end
      hs_cnt = 0;
      i_full = 1'b1;
      @(posedge i_clk); #1;
      i_full = 1'b0;
      n_chk++;
      if (o_valid !== 1'b1 || o_hdr_flag !== 1'b1 || o_busy !== 1'b1)
         $display("FAIL hdr_latency: got valid=%b hdr=%b busy=%b expected 1 1 1", o_valid, o_hdr_flag, o_busy);
      else n_pass++;
      n_chk++;
      if (o_seq !== exp_seq) $display("FAIL hdr_seq: got %h expected %h", o_seq, exp_seq);
      else n_pass++;
      cyc = 1; c = 0;
      while (hs_cnt < 14 && c < 100) begin
         if (stall && hs_cnt == 4) begin
            i_out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
               n_chk++;
               if (o_data !== 8'h45) $display("FAIL stall_hold: got %h expected 45 (cycle %0d)", o_data, k);
               else n_pass++;
               if (k < 3) begin @(posedge i_clk); #1; end
            end
            i_out_ready = 1'b1;
         end
         @(posedge i_clk); #1;
         c++;
         if (o_valid && o_hdr_flag) cyc++;
      end
      n_chk++;
      if (hs_cnt !== 14 || q1.size() != 0)
         $display("FAIL hdr_count: got %0d transfers, %0d left expected 14 and 0", hs_cnt, q1.size());
      else n_pass++;
      if (!stall) begin
         n_chk++;
         if (cyc !== 14) $display("FAIL hdr_duration: got %0d cycles expected 14", cyc);
         else n_pass++;
      end
      n_chk++;
      if (o_valid !== 1'b0 || o_hdr_flag !== 1'b0 || o_pix_ready !== 1'b1 || o_busy !== 1'b0)
         $display("FAIL hdr_to_data: got v=%b h=%b pr=%b busy=%b expected 0 0 1 0",
                  o_valid, o_hdr_flag, o_pix_ready, o_busy);
      else n_pass++;
   endtask

   // Sends n pixels from DATA, ending the packet with the last one; returns in WAIT.
   task automatic send_pixels(input int n, input logic [7:0] base, input bit toggle);
      exp_t e;
      int i, c;
      for (int k = 0; k < n; k++) begin
         e.d = base + 8'(k); e.h = 1'b0; e.len = 15'd8; e.row = 8'd5; e.sof = (k == 0);
         q1.push_back(e);
      end
      i_data_byte = 15'd8; i_row_number = 8'd5;
      i = 0; c = 0;
      while (i < n && c < 200) begin
         i_out_ready = toggle ? (c % 2 == 0) : 1'b1;
         i_pix_valid = 1'b1;
         i_pix_data = base + 8'(i);
         i_sof = (i == 0);
         #1;
         i_packet_last = (i == n-1) && o_pix_ready;
         if (o_pix_ready) i++;
         @(posedge i_clk); #1;
         c++;
      end
      i_pix_valid = 1'b0; i_packet_last = 1'b0; i_sof = 1'b0; i_out_ready = 1'b1;
      c = 0;
      while (q1.size() != 0 && c < 20) begin
         @(posedge i_clk); #1;
         c++;
      end
      n_chk++;
      if (i !== n || q1.size() != 0) $display("FAIL pix_count: sent %0d of %0d, %0d undelivered", i, n, q1.size());
      else n_pass++;
      n_chk++;
      if (o_valid !== 1'b0 || o_busy !== 1'b1 || o_pix_ready !== 1'b0)
         $display("FAIL pix_end_wait: got v=%b busy=%b pr=%b expected 0 1 0", o_valid, o_busy, o_pix_ready);
      else n_pass++;
   endtask

   task automatic test_seq_wrap();
      force u_dut.seq_q = 16'hFFFF;
      @(posedge i_clk); #1;
      release u_dut.seq_q;
      run_header(16'hFFFF, 1'b0);
      send_pixels(1, 8'h40, 1'b0);
      run_header(16'h0000, 1'b0);
      send_pixels(1, 8'h50, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [111:0] hv;
      exp_t e;
      hv = {16'h0001, PARAM};
      for (int i = 0; i < 14; i++) begin
         e.d = hv[111-8*i -: 8]; e.h = 1'b1; e.len = 15'd14; e.row = 8'd0; e.sof = 1'b0;
         q1.push_back(e);
      end
      i_full = 1'b1;
      @(posedge i_clk); #1;
      i_full = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      n_chk++;
      if (o_valid !== 1'b0 || o_seq !== 16'h0000 || o_hdr_flag !== 1'b0 || o_busy !== 1'b0)
         $display("FAIL reset_mid: got v=%b seq=%h h=%b busy=%b expected 0 0000 0 0", o_valid, o_seq, o_hdr_flag, o_busy);
      else n_pass++;
      n_chk++;
      if (q1.size() != 12) $display("FAIL reset_mid_partial: got %0d bytes left expected 12", q1.size());
      else n_pass++;
      q1.delete();
      @(posedge i_clk); #1;
      n_chk++;
      if (o_busy !== 1'b1) $display("FAIL reset_mid_rearm: got busy=%b expected 1", o_busy);
      else n_pass++;
      run_header(16'h0000, 1'b0);
      send_pixels(2, 8'h60, 1'b0);
   endtask

   task automatic test_noseq();
      int c;
      q2.push_back(8'hDE); q2.push_back(8'hAD); q2.push_back(8'hBE); q2.push_back(8'hEF);
      i_out_ready = 1'b1;
      i_full2 = 1'b1;
      @(posedge i_clk); #1;
      i_full2 = 1'b0;
      n_chk++;
      if (o_valid2 !== 1'b1 || o_data_byte2 !== 15'd4 || o_data2 !== 8'hDE)
         $display("FAIL noseq_first: got v=%b len=%0d d=%h expected 1 4 de", o_valid2, o_data_byte2, o_data2);
      else n_pass++;
      c = 0;
      while (q2.size() != 0 && c < 20) begin
         @(posedge i_clk); #1;
         c++;
      end
      n_chk++;
      if (q2.size() != 0 || o_hdr_flag2 !== 1'b0 || o_valid2 !== 1'b0)
         $display("FAIL noseq_done: got %0d left h=%b v=%b expected 0 0 0", q2.size(), o_hdr_flag2, o_valid2);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      run_header(16'h0000, 1'b0);
      send_pixels(8, 8'h10, 1'b1);
      run_header(16'h0001, 1'b1);
      send_pixels(3, 8'h20, 1'b0);
      run_header(16'h0002, 1'b0);
      send_pixels(2, 8'h30, 1'b0);
      test_seq_wrap();
      test_reset_mid();
      test_noseq();
      repeat (2) @(posedge i_clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
